// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flush bubbles and memory-wait freeze.
// Optional performance counters are built when HAZARD_CTRL_PERF_EN is defined.
module hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       ex_valid,
    input  logic       ex_is_load,
    input  logic [4:0] ex_rd,
    input  logic       branch_taken,
    input  logic       mem_busy,
    output logic       pc_ena,
    output logic       if_id_ena,
    output logic       id_ex_ena,
    output logic       pipe_hold,
    output logic [1:0] state
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
`endif
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);

    state_t     state_q;
    logic [1:0] cnt_q;
    logic       pend_q;

    logic load_use;
    logic br_apply;
    logic flushing;

    always_comb begin
        load_use = id_valid && ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                   ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                    (id_uses_rs2 && (id_rs2 == ex_rd)));
        br_apply = branch_taken || pend_q;
        // A non-zero count means flush bubbles remain, whether in FLUSH or frozen in WAIT.
        flushing = (cnt_q != '0);
    end

    always_comb begin
        pc_ena    = 1'b0;
        if_id_ena = 1'b0;
        id_ex_ena = 1'b0;
        pipe_hold = 1'b0;
        if (!rst) begin
            if (mem_busy) begin
                pipe_hold = 1'b1;
                if_id_ena = 1'b1;
                id_ex_ena = 1'b1;
            end else if (br_apply || flushing) begin
                pc_ena = 1'b1;
            end else if (load_use) begin
                // PC held while IF/ID reloads the same fetch word; bubble into ID/EX.
                if_id_ena = 1'b1;
            end else begin
                pc_ena    = 1'b1;
                if_id_ena = 1'b1;
                id_ex_ena = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else if (mem_busy) begin
            state_q <= WAIT;
            if (branch_taken) begin
                pend_q <= 1'b1;
            end
        end else if (br_apply) begin
            pend_q  <= 1'b0;
            cnt_q   <= FLUSH_LOAD;
            state_q <= (FLUSH_LOAD != '0) ? FLUSH : RUN;
        end else if (flushing) begin
            cnt_q   <= cnt_q - 2'd1;
            state_q <= (cnt_q == 2'd1) ? RUN : FLUSH;
        end else begin
            state_q <= RUN;
        end
    end

    assign state = state_q;

`ifdef HAZARD_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (!pc_ena && (stall_count != '1)) begin
                stall_count <= stall_count + 16'd1;
            end
            if (!mem_busy && br_apply && (flush_count != '1)) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized self-checking bench for hazard_ctrl against a rule-level reference model.
// Performance-counter checks are compiled in when HAZARD_CTRL_PERF_EN is defined.
module tb_hazard_ctrl;

    localparam int unsigned FC = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs1 = '0;
    logic [4:0] id_rs2 = '0;
    logic       id_uses_rs1 = 1'b0;
    logic       id_uses_rs2 = 1'b0;
    logic       ex_valid = 1'b0;
    logic       ex_is_load = 1'b0;
    logic [4:0] ex_rd = '0;
    logic       branch_taken = 1'b0;
    logic       mem_busy = 1'b0;
    logic       pc_ena;
    logic       if_id_ena;
    logic       id_ex_ena;
    logic       pipe_hold;
    logic [1:0] state;
`ifdef HAZARD_CTRL_PERF_EN
    logic [15:0] stall_count;
    logic [15:0] flush_count;
`endif

    hazard_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_valid    (ex_valid),
        .ex_is_load  (ex_is_load),
        .ex_rd       (ex_rd),
        .branch_taken(branch_taken),
        .mem_busy    (mem_busy),
        .pc_ena      (pc_ena),
        .if_id_ena   (if_id_ena),
        .id_ex_ena   (id_ex_ena),
        .pipe_hold   (pipe_hold),
        .state       (state)
`ifdef HAZARD_CTRL_PERF_EN
        ,
        .stall_count (stall_count),
        .flush_count (flush_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: visible state, bubbles still owed, and a branch deferred by memory wait.
    logic [1:0] m_state = 2'd0;
    int         m_cnt   = 0;
    bit         m_pend  = 1'b0;
    int         m_stall = 0;
    int         m_flush = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drives one cycle of inputs at the falling edge, checks outputs, then advances the model.
    task automatic drive(input string tag, input logic iv, input logic [4:0] r1, input logic [4:0] r2,
                         input logic u1, input logic u2, input logic ev, input logic el,
                         input logic [4:0] rd, input logic bt, input logic mb);
        logic       hz;
        logic [3:0] e;   // {pc_ena, if_id_ena, id_ex_ena, pipe_hold}
        @(negedge clk);
        id_valid = iv; id_rs1 = r1; id_rs2 = r2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        ex_valid = ev; ex_is_load = el; ex_rd = rd; branch_taken = bt; mem_busy = mb;
        #1;
        hz = iv && ev && el && (rd != 0) && ((u1 && r1 == rd) || (u2 && r2 == rd));
        if (mb)                 e = 4'b0111;
        else if (bt || m_pend)  e = 4'b1000;
        else if (m_cnt > 0)     e = 4'b1000;
        else if (hz)            e = 4'b0100;
        else                    e = 4'b1110;
        check_eq(tag, {26'd0, state, pc_ena, if_id_ena, id_ex_ena, pipe_hold}, {26'd0, m_state, e});
        if (!e[3] && m_stall < 65535) m_stall++;
        if (mb) begin
            m_state = 2'd1;
            if (bt) m_pend = 1'b1;
        end else if (bt || m_pend) begin
            m_pend = 1'b0;
            m_cnt  = FC;
            m_state = (FC > 0) ? 2'd2 : 2'd0;
            if (m_flush < 65535) m_flush++;
        end else if (m_cnt > 0) begin
            m_cnt--;
            m_state = (m_cnt == 0) ? 2'd0 : 2'd2;
        end else begin
            m_state = 2'd0;
        end
    endtask

    // Asserts reset between clock edges so the asynchronous clear is observed before any edge.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #2;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_valid = 0; ex_is_load = 0; ex_rd = 0; branch_taken = 0; mem_busy = 0;
        rst = 1'b1;
        #1;
        check_eq(tag, {26'd0, state, pc_ena, if_id_ena, id_ex_ena, pipe_hold}, 32'd0);
        m_state = 2'd0; m_cnt = 0; m_pend = 1'b0; m_stall = 0; m_flush = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        do_reset("reset_init");

        drive("idle",          0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive("lu_rs1_stall",  1, 5, 7, 1, 1, 1, 1, 5, 0, 0);
        drive("lu_rs1_after",  1, 5, 7, 1, 1, 0, 0, 0, 0, 0);
        drive("lu_rd0",        1, 0, 0, 1, 1, 1, 1, 0, 0, 0);
        drive("lu_rs2_stall",  1, 1, 9, 0, 1, 1, 1, 9, 0, 0);
        drive("lu_rs2_unused", 1, 1, 9, 0, 0, 1, 1, 9, 0, 0);
        drive("lu_not_load",   1, 4, 4, 1, 1, 1, 0, 4, 0, 0);
        drive("lu_id_invalid", 0, 4, 4, 1, 1, 1, 1, 4, 0, 0);

        drive("br_apply",      1, 3, 3, 1, 1, 1, 1, 3, 1, 0);
        drive("br_flush",      1, 3, 3, 1, 1, 1, 1, 3, 0, 0);
        drive("br_run",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        drive("busy1",         0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        drive("busy2_br",      0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        drive("busy3",         0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        drive("pend_apply",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive("pend_flush",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive("pend_run",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        drive("br_a",          0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive("br_in_flush",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive("br_restart",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive("br_done",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        drive("fz_br",         0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive("fz_busy",       0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        drive("fz_resume",     1, 2, 2, 1, 1, 1, 1, 2, 0, 0);
        drive("fz_run",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

`ifdef HAZARD_CTRL_PERF_EN
        check_eq("flush_count_dir", {16'd0, flush_count}, m_flush);
        check_eq("stall_count_dir", {16'd0, stall_count}, m_stall);
`endif

        drive("mf_br",         0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        do_reset("reset_mid_flush");
        drive("mf_after",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        drive("mp_busy_br",    0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        do_reset("reset_pending");
        drive("mp_no_branch",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset("reset_rand");
            end else begin
                drive("rand", 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                      1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 4) == 0));
            end
        end

`ifdef HAZARD_CTRL_PERF_EN
        check_eq("flush_count_rand", {16'd0, flush_count}, m_flush);
        check_eq("stall_count_rand", {16'd0, stall_count}, m_stall);
        do_reset("reset_sat");
        for (int i = 0; i < 70000; i++) begin
            drive("sat", 1, 5, 0, 1, 0, 1, 1, 5, 0, 0);
        end
        @(negedge clk);
        check_eq("stall_count_sat", {16'd0, stall_count}, 32'h0000FFFF);
        check_eq("flush_count_sat", {16'd0, flush_count}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
